mac_arbiter: RTL and testbench



---
 rtl/mac_arbiter_if.sv | 32 +++
 rtl/mac_arbiter.sv | 140 ++++++++++++++
 tb/tb_mac_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_arbiter_if.sv
// Bundle between two requesters, the job arbiter and the shared multiply-accumulate datapath.
// slave = arbiter side, master = requesters plus datapath (drives mac_acc).
interface mac_arbiter_if #(
  parameter int W = 32
);
  logic [1:0]   req;
  logic [1:0]   gnt;
  logic [1:0]   op_vld;
  logic [1:0]   op_rdy;
  logic [W-1:0] op_a0;
  logic [W-1:0] op_b0;
  logic [W-1:0] op_a1;
  logic [W-1:0] op_b1;
  logic [W-1:0] mac_a;
  logic [W-1:0] mac_b;
  logic         mac_en;
  logic         mac_clr;
  logic [W-1:0] mac_acc;
  logic [W-1:0] res;
  logic [1:0]   res_vld;
  logic         busy;

  modport slave (
    input  req, op_vld, op_a0, op_b0, op_a1, op_b1, mac_acc,
    output gnt, op_rdy, mac_a, mac_b, mac_en, mac_clr, res, res_vld, busy
  );

  modport master (
    output req, op_vld, op_a0, op_b0, op_a1, op_b1, mac_acc,
    input  gnt, op_rdy, mac_a, mac_b, mac_en, mac_clr, res, res_vld, busy
  );
endinterface

// File: rtl/mac_arbiter.sv
// Two-requester job sequencer for a shared MAC; res_vld MAC_LAT+2 cycles after the last pair, op_rdy only to the granted requester in STREAM.
// MAC_ARB_FIXED_PRIO_EN: when defined requester 0 always wins simultaneous requests, otherwise round-robin.
module mac_arbiter #(
  parameter int W       = 32,
  parameter int LEN     = 128,
  parameter int MAC_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  mac_arbiter_if.slave bus
);
  localparam int CW = $clog2(LEN + 1);
  localparam int DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 2);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] drn_q, drn_d;
  logic [W-1:0]  mac_a_q, mac_a_d;
  logic [W-1:0]  mac_b_q, mac_b_d;
  logic          mac_en_q, mac_en_d;
  logic [W-1:0]  res_q, res_d;
  logic [1:0]    res_vld_q, res_vld_d;

  logic [1:0]    op_rdy;
  logic          hold;
  logic          accept;
  logic          last_pair;
  logic          drain_done;
  logic          win;

  // hold: the granted requester still wants its job; dropping it aborts
  assign hold       = |(gnt_q & bus.req);
  assign op_rdy     = (state_q == STREAM) ? (gnt_q & bus.req) : 2'b00;
  assign accept     = |(op_rdy & bus.op_vld);
  assign last_pair  = (cnt_q == CW'(LEN - 1));
  assign drain_done = (drn_q == DW'(MAC_LAT));

`ifdef MAC_ARB_FIXED_PRIO_EN
  assign win = ~bus.req[0];
`else
  assign win = (&bus.req) ? ~last_q : bus.req[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      drn_q     <= '0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_en_q  <= 1'b0;
      res_q     <= '0;
      res_vld_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      drn_q     <= drn_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
      mac_en_q  <= mac_en_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req) state_d = CLEAR;
      CLEAR:   state_d = hold ? STREAM : IDLE;
      STREAM: begin
        if (!hold)                      state_d = IDLE;
        else if (accept && last_pair)   state_d = DRAIN;
      end
      DRAIN: begin
        if (!hold)           state_d = IDLE;
        else if (drain_done) state_d = RESULT;
      end
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    drn_d     = drn_q;
    mac_a_d   = mac_a_q;
    mac_b_d   = mac_b_q;
    mac_en_d  = accept;
    res_d     = res_q;
    res_vld_d = 2'b00;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d  = win ? 2'b10 : 2'b01;
          last_d = win;
        end
      end
      CLEAR: cnt_d = '0;
      STREAM: begin
        drn_d = '0;
        if (accept) begin
          cnt_d   = cnt_q + CW'(1);
          mac_a_d = gnt_q[1] ? bus.op_a1 : bus.op_a0;
          mac_b_d = gnt_q[1] ? bus.op_b1 : bus.op_b0;
        end
      end
      DRAIN: begin
        drn_d = drn_q + DW'(1);
        // mac_acc now includes the last pair; it becomes res on entry to RESULT
        if (drain_done && hold) begin
          res_d     = bus.mac_acc;
          res_vld_d = gnt_q;
        end
      end
      default: ;
    endcase
    if (state_q == RESULT || (state_q != IDLE && !hold)) gnt_d = 2'b00;
  end

  assign bus.gnt     = gnt_q;
  assign bus.op_rdy  = op_rdy;
  assign bus.mac_a   = mac_a_q;
  assign bus.mac_b   = mac_b_q;
  assign bus.mac_en  = mac_en_q;
  assign bus.mac_clr = (state_q == CLEAR);
  assign bus.res     = res_q;
  assign bus.res_vld = res_vld_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench: a LEN=4 arbiter for job/arbitration scenarios and a LEN=128 one for long/abort jobs,
// each backed by a two-stage Q16.16 MAC datapath model (MAC_LAT=2).
`timescale 1ns/1ps
module tb_mac_arbiter;
  localparam int W       = 32;
  localparam int MAC_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mac_arbiter_if #(.W(W)) bus ();
  mac_arbiter_if #(.W(W)) bus2 ();

  mac_arbiter #(.W(W), .LEN(4),   .MAC_LAT(MAC_LAT)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  mac_arbiter #(.W(W), .LEN(128), .MAC_LAT(MAC_LAT)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return W'(p >>> 16);
  endfunction

  logic [W-1:0] p1, p2;
  logic         p1_vld, p2_vld;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_vld <= 1'b0; p1 <= '0; bus.mac_acc <= '0;
      p2_vld <= 1'b0; p2 <= '0; bus2.mac_acc <= '0;
    end else begin
      p1_vld <= bus.mac_en;  p1 <= qmul(bus.mac_a, bus.mac_b);
      p2_vld <= bus2.mac_en; p2 <= qmul(bus2.mac_a, bus2.mac_b);
      if (bus.mac_clr)  bus.mac_acc <= '0;  else if (p1_vld) bus.mac_acc <= bus.mac_acc + p1;
      if (bus2.mac_clr) bus2.mac_acc <= '0; else if (p2_vld) bus2.mac_acc <= bus2.mac_acc + p2;
    end
  end

  // Drives whichever requester holds the grant on the LEN=4 instance until a result appears.
  task automatic do_job(input bit keep_req, input bit noise, output logic [1:0] who,
                        output int n_en, output int n_clr, output int lat,
                        output logic [W-1:0] r, output logic [1:0] rv, output int bad);
    int acc;
    int last;
    acc = 0; last = 0; who = 2'b00; n_en = 0; n_clr = 0; lat = -1; r = '0; rv = 2'b00; bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      bus.op_vld = (acc < 4) ? bus.gnt : 2'b00;
      if (noise) bus.op_vld[1] = 1'b1;
      #1;
      if (bus.gnt != 2'b00) who = bus.gnt;
      if (bus.mac_en) n_en++;
      if (bus.mac_clr) n_clr++;
      if (noise && (bus.op_rdy[1] || bus.mac_a == bus.op_a1)) bad++;
      if ((bus.op_vld & bus.op_rdy) != 2'b00) begin acc++; last = k; end
      if (bus.res_vld != 2'b00) begin
        lat = k - last; r = bus.res; rv = bus.res_vld;
        if (!keep_req) bus.req = bus.req & ~bus.res_vld;
        break;
      end
    end
    bus.op_vld = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.req = 2'b01; bus2.req = 2'b01;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (bus.gnt !== 2'b00)     begin n_fail++; $display("FAIL reset_gnt got=%h exp=0", bus.gnt); end
    n_tests++; if (bus.op_rdy !== 2'b00)  begin n_fail++; $display("FAIL reset_op_rdy got=%h exp=0", bus.op_rdy); end
    n_tests++; if (bus.mac_en !== 1'b0)   begin n_fail++; $display("FAIL reset_mac_en got=%b exp=0", bus.mac_en); end
    n_tests++; if (bus.mac_clr !== 1'b0)  begin n_fail++; $display("FAIL reset_mac_clr got=%b exp=0", bus.mac_clr); end
    n_tests++; if (bus.mac_a !== 32'h0 || bus.mac_b !== 32'h0) begin n_fail++; $display("FAIL reset_mac_ab got=%h/%h exp=0", bus.mac_a, bus.mac_b); end
    n_tests++; if (bus.res !== 32'h0)     begin n_fail++; $display("FAIL reset_res got=%h exp=0", bus.res); end
    n_tests++; if (bus.res_vld !== 2'b00) begin n_fail++; $display("FAIL reset_res_vld got=%h exp=0", bus.res_vld); end
    n_tests++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus2.gnt !== 2'b00 || bus2.busy !== 1'b0) begin n_fail++; $display("FAIL reset_dut2 gnt=%h busy=%b exp=0", bus2.gnt, bus2.busy); end
    bus.req = 2'b00; bus2.req = 2'b00;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single();
    logic [1:0] who, rv; int n_en, n_clr, lat, bad; logic [W-1:0] r;
    @(negedge clk); bus.req = 2'b01; #1;
    n_tests++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL single_gnt_early got=%h exp=0", bus.gnt); end
    do_job(1'b0, 1'b0, who, n_en, n_clr, lat, r, rv, bad);
    n_tests++; if (who !== 2'b01)       begin n_fail++; $display("FAIL single_gnt got=%h exp=01", who); end
    n_tests++; if (n_clr != 1)          begin n_fail++; $display("FAIL single_clr_cycles got=%0d exp=1", n_clr); end
    n_tests++; if (n_en != 4)           begin n_fail++; $display("FAIL single_mac_en got=%0d exp=4", n_en); end
    n_tests++; if (lat != MAC_LAT + 2)  begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", lat, MAC_LAT + 2); end
    n_tests++; if (r !== 32'h0008_0000) begin n_fail++; $display("FAIL single_res got=%h exp=00080000", r); end
    n_tests++; if (rv !== 2'b01)        begin n_fail++; $display("FAIL single_res_vld got=%h exp=01", rv); end
    @(negedge clk); #1;
    n_tests++; if (bus.res_vld !== 2'b00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_after res_vld=%h busy=%b exp=0/0", bus.res_vld, bus.busy); end
    n_tests++; if (bus.res !== 32'h0008_0000) begin n_fail++; $display("FAIL single_res_hold got=%h exp=00080000", bus.res); end
  endtask

  task automatic test_round_robin();
    logic [1:0] who, rv, exp4; int n_en, n_clr, lat, bad; logic [W-1:0] r;
`ifdef MAC_ARB_FIXED_PRIO_EN
    exp4 = 2'b01;
`else
    exp4 = 2'b10;
`endif
    @(negedge clk); rst = 1'b0; #1;
    @(negedge clk); rst = 1'b1; bus.req = 2'b11;
    do_job(1'b0, 1'b0, who, n_en, n_clr, lat, r, rv, bad);
    n_tests++; if (who !== 2'b01 || r !== 32'h0008_0000) begin n_fail++; $display("FAIL rr_job1 gnt=%h res=%h exp=01/00080000", who, r); end
    do_job(1'b0, 1'b0, who, n_en, n_clr, lat, r, rv, bad);
    n_tests++; if (who !== 2'b10 || r !== 32'h0006_0000 || rv !== 2'b10) begin n_fail++; $display("FAIL rr_job2 gnt=%h res=%h vld=%h exp=10/00060000/10", who, r, rv); end
    bus.req = 2'b11;
    do_job(1'b1, 1'b0, who, n_en, n_clr, lat, r, rv, bad);
    n_tests++; if (who !== 2'b01) begin n_fail++; $display("FAIL rr_job3 gnt=%h exp=01", who); end
    do_job(1'b0, 1'b0, who, n_en, n_clr, lat, r, rv, bad);
    n_tests++; if (who !== exp4) begin n_fail++; $display("FAIL rr_job4 gnt=%h exp=%h", who, exp4); end
    n_tests++; if (r !== ((exp4 == 2'b01) ? 32'h0008_0000 : 32'h0006_0000)) begin n_fail++; $display("FAIL rr_job4_res got=%h", r); end
    bus.req = 2'b00;
  endtask

  task automatic test_mid_reset();
    logic [1:0] who, rv; int n_en, n_clr, lat, bad; logic [W-1:0] r;
    @(negedge clk); bus.req = 2'b01;
    repeat (4) begin @(negedge clk); bus.op_vld = bus.gnt; end
    #1;
    n_tests++; if (bus.op_rdy !== 2'b01 || bus.mac_en !== 1'b1) begin n_fail++; $display("FAIL midrst_streaming op_rdy=%h mac_en=%b exp=01/1", bus.op_rdy, bus.mac_en); end
    rst = 1'b0; #1;
    n_tests++; if (bus.gnt !== 2'b00 || bus.op_rdy !== 2'b00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl gnt=%h op_rdy=%h busy=%b exp=0", bus.gnt, bus.op_rdy, bus.busy); end
    n_tests++; if (bus.mac_en !== 1'b0 || bus.mac_clr !== 1'b0 || bus.res_vld !== 2'b00) begin n_fail++; $display("FAIL midrst_strobes en=%b clr=%b vld=%h exp=0", bus.mac_en, bus.mac_clr, bus.res_vld); end
    n_tests++; if (bus.mac_a !== 32'h0 || bus.mac_b !== 32'h0 || bus.res !== 32'h0) begin n_fail++; $display("FAIL midrst_data a=%h b=%h res=%h exp=0", bus.mac_a, bus.mac_b, bus.res); end
    bus.op_vld = 2'b00;
    @(negedge clk); rst = 1'b1;
    do_job(1'b0, 1'b0, who, n_en, n_clr, lat, r, rv, bad);
    n_tests++; if (r !== 32'h0008_0000 || rv !== 2'b01 || n_en != 4) begin n_fail++; $display("FAIL midrst_newjob res=%h vld=%h en=%0d exp=00080000/01/4", r, rv, n_en); end
  endtask

  task automatic test_foreign();
    logic [1:0] who, rv; int n_en, n_clr, lat, bad; logic [W-1:0] r;
    bus.op_a1 = 32'h7777_0000; bus.op_b1 = 32'h7777_0000; bus.req = 2'b01;
    do_job(1'b0, 1'b1, who, n_en, n_clr, lat, r, rv, bad);
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL foreign_ignored got=%0d bad cycles exp=0", bad); end
    n_tests++; if (r !== 32'h0008_0000 || rv !== 2'b01) begin n_fail++; $display("FAIL foreign_res res=%h vld=%h exp=00080000/01", r, rv); end
    bus.op_a1 = 32'h0003_0000; bus.op_b1 = 32'h0000_8000;
  endtask

  task automatic test_abort();
    int acc, seen;
    acc = 0; seen = 0;
    @(negedge clk); bus2.req = 2'b11;
    for (int k = 0; k < 40 && acc < 10; k++) begin
      @(negedge clk); bus2.op_vld = bus2.gnt; #1;
      if (bus2.res_vld != 2'b00) seen++;
      if ((bus2.op_vld & bus2.op_rdy) != 2'b00) acc++;
    end
    n_tests++; if (acc != 10 || bus2.gnt !== 2'b01) begin n_fail++; $display("FAIL abort_setup pairs=%0d gnt=%h exp=10/01", acc, bus2.gnt); end
    @(negedge clk); bus2.req = 2'b10; #1;
    n_tests++; if (bus2.op_rdy !== 2'b00) begin n_fail++; $display("FAIL abort_op_rdy got=%h exp=0", bus2.op_rdy); end
    @(negedge clk); #1;
    n_tests++; if (bus2.busy !== 1'b0 || bus2.gnt !== 2'b00) begin n_fail++; $display("FAIL abort_idle busy=%b gnt=%h exp=0/0", bus2.busy, bus2.gnt); end
    n_tests++; if (bus2.mac_en !== 1'b0 || bus2.res_vld !== 2'b00) begin n_fail++; $display("FAIL abort_strobes en=%b vld=%h exp=0/0", bus2.mac_en, bus2.res_vld); end
    bus2.op_vld = 2'b00;
    @(negedge clk); #1;
    n_tests++; if (bus2.gnt !== 2'b10 || bus2.mac_clr !== 1'b1) begin n_fail++; $display("FAIL abort_next_gnt gnt=%h clr=%b exp=10/1", bus2.gnt, bus2.mac_clr); end
    bus2.req = 2'b00;
    @(negedge clk); #1;
    if (bus2.res_vld != 2'b00) seen++;
    n_tests++; if (bus2.busy !== 1'b0 || seen != 0) begin n_fail++; $display("FAIL abort_cleanup busy=%b res_vld_seen=%0d exp=0/0", bus2.busy, seen); end
  endtask

  task automatic test_toggle();
    int acc, last, n_en, lat;
    bit phase;
    logic [W-1:0] r; logic [1:0] rv;
    acc = 0; last = 0; n_en = 0; lat = -1; phase = 1'b0; r = '0; rv = 2'b00;
    bus2.op_a0 = 32'h0000_8000;
    @(negedge clk); bus2.req = 2'b01;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      phase = ~phase;
      bus2.op_vld = (phase && acc < 128) ? bus2.gnt : 2'b00;
      bus2.op_b0 = W'((acc + 1) << 16);
      #1;
      if (bus2.mac_en) n_en++;
      if ((bus2.op_vld & bus2.op_rdy) != 2'b00) begin acc++; last = k; end
      if (bus2.res_vld != 2'b00) begin lat = k - last; r = bus2.res; rv = bus2.res_vld; break; end
    end
    bus2.req = 2'b00; bus2.op_vld = 2'b00;
    n_tests++; if (n_en != 128)         begin n_fail++; $display("FAIL toggle_mac_en got=%0d exp=128", n_en); end
    n_tests++; if (r !== 32'h1020_0000) begin n_fail++; $display("FAIL toggle_res got=%h exp=10200000", r); end
    n_tests++; if (rv !== 2'b01 || lat != MAC_LAT + 2) begin n_fail++; $display("FAIL toggle_vld vld=%h lat=%0d exp=01/%0d", rv, lat, MAC_LAT + 2); end
  endtask

  initial begin
    rst = 1'b0;
    bus.req = 2'b00;  bus.op_vld = 2'b00;
    bus.op_a0 = 32'h0001_0000; bus.op_b0 = 32'h0002_0000;
    bus.op_a1 = 32'h0003_0000; bus.op_b1 = 32'h0000_8000;
    bus2.req = 2'b00; bus2.op_vld = 2'b00;
    bus2.op_a0 = 32'h0001_0000; bus2.op_b0 = 32'h0002_0000;
    bus2.op_a1 = 32'h0003_0000; bus2.op_b1 = 32'h0000_8000;
    test_reset();
    test_single();
    test_round_robin();
    test_mid_reset();
    test_foreign();
    test_abort();
    test_toggle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
